// File: rtl/queue_beat_packer_pkg.sv
// queue_beat_packer_pkg: shared stream types and REQ/ACK helpers for the Queue-family blocks.
package queue_beat_packer_pkg;
   typedef enum logic {FILL, HOLD} packer_state_e;
   function automatic int lane_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
   function automatic logic xfer(input logic ack, input logic req);
      return ack & req;
   endfunction
endpackage

// File: rtl/queue_beat_packer_if.sv
// queue_beat_packer_if: narrow beat input and wide word output, both REQ/ACK.
interface queue_beat_packer_if #(
   parameter int BitWidth     = 32,
   parameter int BeatsPerWord = 4
);
   localparam int CntWidth = $clog2(BeatsPerWord) + 1;
   logic                             dInACK;
   logic                             dInREQ;
   logic [BitWidth-1:0]              dIN;
   logic                             flush;
   logic                             dOutACK;
   logic                             dOutREQ;
   logic [BitWidth*BeatsPerWord-1:0] dOUT;
   logic [CntWidth-1:0]              dOutBeats;
   modport master (input dInACK, dIN, flush, dOutREQ, output dInREQ, dOutACK, dOUT, dOutBeats);
   modport slave  (output dInACK, dIN, flush, dOutREQ, input dInREQ, dOutACK, dOUT, dOutBeats);
endinterface

// File: rtl/queue_beat_packer_lane_reg.sv
// queue_beat_packer_lane_reg: BeatsPerWord x BitWidth lane accumulator with per-lane write and clear.
module queue_beat_packer_lane_reg #(
   parameter int BitWidth     = 32,
   parameter int BeatsPerWord = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             i_clr,
   input  logic [BeatsPerWord-1:0]          i_we,
   input  logic [BitWidth-1:0]              i_d,
   output logic [BitWidth*BeatsPerWord-1:0] o_lanes
);
   for (genvar g = 0; g < BeatsPerWord; g++) begin : g_lane
      logic [BitWidth-1:0] r_lane;
      always_ff @(posedge clk or negedge rst)
         if (!rst)          r_lane <= '0;
         else if (i_clr)    r_lane <= '0;
         else if (i_we[g])  r_lane <= i_d;
      assign o_lanes[g*BitWidth +: BitWidth] = r_lane;
   end
endmodule

// File: rtl/queue_beat_packer.sv
// queue_beat_packer: packs BeatsPerWord narrow REQ/ACK beats into one wide REQ/ACK word.
module queue_beat_packer
   import queue_beat_packer_pkg::*;
#(
   parameter int BitWidth     = 32,
   parameter int BeatsPerWord = 4
) (
   input logic                clk,
   input logic                rst,
   queue_beat_packer_if.master bus
);
   localparam int CntWidth = $clog2(BeatsPerWord) + 1;
   localparam int LaneW    = lane_w(BeatsPerWord);
   packer_state_e                    r_state, w_state_nxt;
   logic [CntWidth-1:0]              r_cnt, r_beats, w_total;
   logic [BitWidth*BeatsPerWord-1:0] r_dout, w_lanes, w_word;
   logic [BeatsPerWord-1:0]          w_we;
   logic                             w_in_xfer, w_out_xfer, w_emit;
   assign bus.dInREQ   = (r_state == FILL) | bus.dOutREQ;
   assign bus.dOutACK  = (r_state == HOLD);
   assign bus.dOUT     = r_dout;
   assign bus.dOutBeats = r_beats;
   assign w_in_xfer  = xfer(bus.dInACK, bus.dInREQ);
   assign w_out_xfer = xfer(bus.dOutACK, bus.dOutREQ);
   assign w_total    = r_cnt + CntWidth'(w_in_xfer);
   // A flush counts only when it could also have carried a beat, and never emits an empty word.
   assign w_emit = (w_total == CntWidth'(BeatsPerWord)) | (bus.flush & bus.dInREQ & (w_total != '0));
   assign w_we   = w_in_xfer ? (BeatsPerWord'(1) << r_cnt) : '0;
   // The arriving beat is merged here so the completing word never waits on the lane registers.
   always_comb begin
      w_word = w_lanes;
      if (w_in_xfer) w_word[r_cnt[LaneW-1:0]*BitWidth +: BitWidth] = bus.dIN;
   end
   always_comb w_state_nxt = w_emit ? HOLD : w_out_xfer ? FILL : r_state;
   always_ff @(posedge clk or negedge rst)
      if (!rst) r_state <= FILL;
      else      r_state <= w_state_nxt;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_cnt   <= '0;
         r_beats <= '0;
         r_dout  <= '0;
      end else begin
         r_cnt <= w_emit ? '0 : w_total;
         if (w_emit) begin
            r_dout  <= w_word;
            r_beats <= w_total;
         end
      end
   queue_beat_packer_lane_reg #(.BitWidth(BitWidth), .BeatsPerWord(BeatsPerWord)) u_lanes (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (w_emit),
      .i_we    (w_we),
      .i_d     (bus.dIN),
      .o_lanes (w_lanes)
   );
endmodule
